// File: rtl/operand_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// operand_fetch_stage_if
// Bundles every non-clock signal of the operand fetch stage.
//   id_*        : decoded instruction in, valid/ready handshake (id_ready out)
//   rf_rd*_addr : register file read addresses (out of the stage)
//   rf_rd*_data : register file combinational read data (into the stage)
//   wb_*        : same-cycle writeback (register file write port mirror)
//   flush       : kill the instruction held for execute
//   ex_*        : registered operands to execute, valid/ready handshake
// modport master : environment side (decode, register file, writeback, execute)
// modport slave  : the operand fetch stage itself
// ----------------------------------------------------------------------------
interface operand_fetch_stage_if #(
   parameter int unsigned OP_W = 4
);
   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_AW = 3;

   // Decode side
   logic                id_valid;
   logic                id_ready;
   logic [OP_W-1:0]     id_op;
   logic [REG_AW-1:0]   id_src0;
   logic [REG_AW-1:0]   id_src1;
   logic [REG_AW-1:0]   id_dst;
   logic                id_wb;
   logic                id_use_imm;
   logic [DATA_W-1:0]   id_imm;

   // Register file read ports
   logic [REG_AW-1:0]   rf_rd0_addr;
   logic [REG_AW-1:0]   rf_rd1_addr;
   logic [DATA_W-1:0]   rf_rd0_data;
   logic [DATA_W-1:0]   rf_rd1_data;

   // Writeback
   logic                wb_en;
   logic [REG_AW-1:0]   wb_addr;
   logic [DATA_W-1:0]   wb_data;

   // Pipeline control
   logic                flush;

   // Execute side
   logic                ex_valid;
   logic                ex_ready;
   logic [OP_W-1:0]     ex_op;
   logic [DATA_W-1:0]   ex_a;
   logic [DATA_W-1:0]   ex_b;
   logic [REG_AW-1:0]   ex_dst;
   logic                ex_wb;

   modport master (
      output id_valid, id_op, id_src0, id_src1, id_dst, id_wb, id_use_imm, id_imm,
      input  id_ready,
      input  rf_rd0_addr, rf_rd1_addr,
      output rf_rd0_data, rf_rd1_data,
      output wb_en, wb_addr, wb_data,
      output flush,
      input  ex_valid, ex_op, ex_a, ex_b, ex_dst, ex_wb,
      output ex_ready
   );

   modport slave (
      input  id_valid, id_op, id_src0, id_src1, id_dst, id_wb, id_use_imm, id_imm,
      output id_ready,
      output rf_rd0_addr, rf_rd1_addr,
      input  rf_rd0_data, rf_rd1_data,
      input  wb_en, wb_addr, wb_data,
      input  flush,
      output ex_valid, ex_op, ex_a, ex_b, ex_dst, ex_wb,
      input  ex_ready
   );
endinterface

// File: rtl/operand_fetch_stage.sv
// ----------------------------------------------------------------------------
// operand_fetch_stage
// Sits between decode and execute in front of the 8x16 register file.
// Drives the register file read addresses straight from the decoded sources,
// forwards same-cycle writeback data, stalls on an 8-entry busy scoreboard
// (RAW on either source, WAW on the destination) and registers the operand
// bundle for execute.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : operand_fetch_stage_if.slave (decode, register file, writeback,
//           flush and execute signals)
// ----------------------------------------------------------------------------
module operand_fetch_stage #(
   parameter int unsigned OP_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   operand_fetch_stage_if.slave   bus
);
   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_AW = 3;
   localparam int unsigned NREG   = 8;

   // Architectural state
   logic [NREG-1:0]     r_busy;
   logic                r_ex_valid;
   logic [OP_W-1:0]     r_ex_op;
   logic [DATA_W-1:0]   r_ex_a;
   logic [DATA_W-1:0]   r_ex_b;
   logic [REG_AW-1:0]   r_ex_dst;
   logic                r_ex_wb;

   // Combinational helpers
   logic [NREG-1:0]     w_clr;
   logic [NREG-1:0]     w_eb;
   logic [NREG-1:0]     w_set;
   logic [NREG-1:0]     w_kill;
   logic                w_hazard;
   logic                w_ready;
   logic                w_issue;
   logic                w_fwd0;
   logic                w_fwd1;
   logic [DATA_W-1:0]   w_op_a;
   logic [DATA_W-1:0]   w_op_b;

   // Register file read addresses come straight from decode
   assign bus.rf_rd0_addr = bus.id_src0;
   assign bus.rf_rd1_addr = bus.id_src1;

   // Writeback retires its busy bit in the same cycle it is observed
   always_comb begin
      w_clr = '0;
      if (bus.wb_en) begin
         w_clr = NREG'(1) << bus.wb_addr;
      end
   end

   assign w_eb = r_busy & ~w_clr;

   // RAW on A, RAW on B (only when B is a register), WAW on destination
   always_comb begin
      w_hazard = 1'b0;
      if (w_eb[bus.id_src0]) begin
         w_hazard = 1'b1;
      end
      if (!bus.id_use_imm && w_eb[bus.id_src1]) begin
         w_hazard = 1'b1;
      end
      if (bus.id_wb && w_eb[bus.id_dst]) begin
         w_hazard = 1'b1;
      end
   end

   // Ready is independent of id_valid so decode may use it to decide issue
   assign w_ready  = !bus.flush && (!r_ex_valid || bus.ex_ready) && !w_hazard;
   assign w_issue  = bus.id_valid && w_ready;
   assign bus.id_ready = w_ready;

   // The register file writes at the clock edge, so its read data is stale
   // for a register being written this cycle; take the writeback bus instead.
   assign w_fwd0 = bus.wb_en && (bus.wb_addr == bus.id_src0);
   assign w_fwd1 = bus.wb_en && (bus.wb_addr == bus.id_src1);

   always_comb begin
      w_op_a = bus.rf_rd0_data;
      if (w_fwd0) begin
         w_op_a = bus.wb_data;
      end
   end

   always_comb begin
      w_op_b = bus.rf_rd1_data;
      if (bus.id_use_imm) begin
         w_op_b = bus.id_imm;
      end else if (w_fwd1) begin
         w_op_b = bus.wb_data;
      end
   end

   // Destination of an issuing writer becomes busy
   always_comb begin
      w_set = '0;
      if (w_issue && bus.id_wb) begin
         w_set = NREG'(1) << bus.id_dst;
      end
   end

   // A flushed writer that execute never took gives its busy bit back;
   // if execute accepted it in the same cycle it stays outstanding.
   always_comb begin
      w_kill = '0;
      if (bus.flush && r_ex_valid && r_ex_wb && !bus.ex_ready) begin
         w_kill = NREG'(1) << r_ex_dst;
      end
   end

   // Scoreboard: set is OR-ed last so it wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr & ~w_kill) | w_set;
      end
   end

   // Execute output register: load on issue, drop when consumed or flushed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid <= 1'b0;
         r_ex_op    <= '0;
         r_ex_a     <= '0;
         r_ex_b     <= '0;
         r_ex_dst   <= '0;
         r_ex_wb    <= 1'b0;
      end else begin
         if (w_issue) begin
            r_ex_valid <= 1'b1;
            r_ex_op    <= bus.id_op;
            r_ex_a     <= w_op_a;
            r_ex_b     <= w_op_b;
            r_ex_dst   <= bus.id_dst;
            r_ex_wb    <= bus.id_wb;
         end else if (bus.flush || bus.ex_ready) begin
            r_ex_valid <= 1'b0;
         end
      end
   end

   assign bus.ex_valid = r_ex_valid;
   assign bus.ex_op    = r_ex_op;
   assign bus.ex_a     = r_ex_a;
   assign bus.ex_b     = r_ex_b;
   assign bus.ex_dst   = r_ex_dst;
   assign bus.ex_wb    = r_ex_wb;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_operand_fetch_stage
// Directed bench for operand_fetch_stage. A small register file model feeds
// the read ports; expected execute bundles are queued when an instruction is
// expected to issue and compared when execute takes them.
// ----------------------------------------------------------------------------
module tb_operand_fetch_stage;
   localparam int unsigned OP_W = 4;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [15:0]     a;
      logic [15:0]     b;
      logic [2:0]      dst;
      logic            wb;
   } ex_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   operand_fetch_stage_if #(.OP_W(OP_W)) bus ();

   operand_fetch_stage #(.OP_W(OP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] rf [8];
   assign bus.rf_rd0_data = rf[bus.rf_rd0_addr];
   assign bus.rf_rd1_data = rf[bus.rf_rd1_addr];

   ex_t sb[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [OP_W-1:0] op,
                        input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] d,
                        input logic wb, input logic use_imm, input logic [15:0] imm);
      bus.id_valid   = v;
      bus.id_op      = op;
      bus.id_src0    = s0;
      bus.id_src1    = s1;
      bus.id_dst     = d;
      bus.id_wb      = wb;
      bus.id_use_imm = use_imm;
      bus.id_imm     = imm;
   endtask

   task automatic set_wb(input logic en, input logic [2:0] addr, input logic [15:0] data);
      bus.wb_en   = en;
      bus.wb_addr = addr;
      bus.wb_data = data;
   endtask

   // One clock: check ready, score any execute handshake, queue an expected
   // issue, then apply the register file write after the edge.
   task automatic tick(input logic exp_ready, input string tag);
      ex_t e;
      ex_t got;
      logic w_en;
      logic [2:0] w_a;
      logic [15:0] w_d;
      @(negedge clk);
      chk({tag, "_rdy"}, 64'(bus.id_ready), 64'(exp_ready));
      if (bus.ex_valid && bus.ex_ready) begin
         got.op  = bus.ex_op;
         got.a   = bus.ex_a;
         got.b   = bus.ex_b;
         got.dst = bus.ex_dst;
         got.wb  = bus.ex_wb;
         if (sb.size() == 0) begin
            chk({tag, "_unexpected_ex"}, 64'(bus.ex_valid), 64'(0));
         end else begin
            e = sb.pop_front();
            chk({tag, "_ex"}, 64'(got), 64'(e));
         end
      end
      if (bus.id_valid && exp_ready) begin
         e.op  = bus.id_op;
         e.a   = (bus.wb_en && bus.wb_addr == bus.id_src0) ? bus.wb_data : rf[bus.id_src0];
         e.b   = bus.id_use_imm ? bus.id_imm :
                 ((bus.wb_en && bus.wb_addr == bus.id_src1) ? bus.wb_data : rf[bus.id_src1]);
         e.dst = bus.id_dst;
         e.wb  = bus.id_wb;
         sb.push_back(e);
      end
      w_en = bus.wb_en;
      w_a  = bus.wb_addr;
      w_d  = bus.wb_data;
      @(posedge clk);
      #1;
      if (w_en) rf[w_a] = w_d;
   endtask

   initial begin
      ex_t discard;
      for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
      rf[0] = 16'h0A0A;
      rf[1] = 16'h1111;
      rf[2] = 16'h2222;
      rst_n = 1'b0;
      drive(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0);
      set_wb(1'b0, 3'd0, 16'h0);
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_ex_valid", 64'(bus.ex_valid), 64'(0));
      chk("rst_busy", 64'(dut.r_busy), 64'(0));
      chk("rst_ex_fields", 64'({bus.ex_op, bus.ex_a, bus.ex_b, bus.ex_dst, bus.ex_wb}), 64'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Idle, then a plain two-register issue
      tick(1'b1, "idle");
      drive(1'b1, 4'h1, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 16'h0);
      tick(1'b1, "basic");
      chk("basic_ex_valid", 64'(bus.ex_valid), 64'(1));
      chk("basic_ex_a", 64'(bus.ex_a), 64'(16'h1111));
      chk("basic_ex_b", 64'(bus.ex_b), 64'(16'h2222));

      // Writeback forwarding onto operand A (register not busy)
      drive(1'b1, 4'h2, 3'd3, 3'd2, 3'd1, 1'b0, 1'b0, 16'h0);
      set_wb(1'b1, 3'd3, 16'hBEEF);
      tick(1'b1, "fwd");
      chk("fwd_ex_a", 64'(bus.ex_a), 64'(16'hBEEF));

      // RAW stall until the writeback cycle, which issues with forwarded data
      set_wb(1'b0, 3'd0, 16'h0);
      drive(1'b1, 4'h3, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 16'h0);
      tick(1'b1, "raw_set");
      chk("raw_busy_set", 64'(dut.r_busy), 64'(8'h10));
      drive(1'b1, 4'h4, 3'd4, 3'd0, 3'd6, 1'b0, 1'b0, 16'h0);
      tick(1'b0, "raw_stall1");
      tick(1'b0, "raw_stall2");
      set_wb(1'b1, 3'd4, 16'h4444);
      tick(1'b1, "raw_wb");
      chk("raw_ex_a", 64'(bus.ex_a), 64'(16'h4444));
      chk("raw_busy_clr", 64'(dut.r_busy), 64'(0));

      // Immediate operand ignores a busy src1
      set_wb(1'b0, 3'd0, 16'h0);
      drive(1'b1, 4'h5, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 16'h0);
      tick(1'b1, "imm_set");
      drive(1'b1, 4'h6, 3'd1, 3'd4, 3'd7, 1'b0, 1'b1, 16'h00FF);
      tick(1'b1, "imm");
      chk("imm_ex_b", 64'(bus.ex_b), 64'(16'h00FF));
      drive(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0);
      set_wb(1'b1, 3'd4, 16'h5555);
      tick(1'b1, "imm_clr");
      chk("imm_busy_clr", 64'(dut.r_busy), 64'(0));

      // Backpressure: output holds for 5 cycles, next loads on release
      set_wb(1'b0, 3'd0, 16'h0);
      bus.ex_ready = 1'b0;
      drive(1'b1, 4'h7, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 16'h0);
      tick(1'b1, "bp_issue");
      drive(1'b1, 4'h8, 3'd2, 3'd1, 3'd3, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, "bp_hold");
         chk("bp_hold_bundle", 64'({bus.ex_valid, bus.ex_op, bus.ex_a, bus.ex_b}),
             64'({1'b1, 4'h7, 16'h1111, 16'h2222}));
      end
      bus.ex_ready = 1'b1;
      tick(1'b1, "bp_release");
      chk("bp_next_op", 64'(bus.ex_op), 64'(4'h8));

      // Flush of an unaccepted writer releases its busy bit
      drive(1'b1, 4'h9, 3'd1, 3'd1, 3'd5, 1'b1, 1'b0, 16'h0);
      tick(1'b1, "fl_issue");
      bus.ex_ready = 1'b0;
      bus.flush    = 1'b1;
      drive(1'b1, 4'hA, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 16'h0);
      tick(1'b0, "fl_kill");
      discard = sb.pop_back();
      chk("fl_ex_valid", 64'(bus.ex_valid), 64'(0));
      chk("fl_busy", 64'(dut.r_busy), 64'(0));

      // Flush while execute accepts: handed off, busy bit kept
      bus.flush    = 1'b0;
      bus.ex_ready = 1'b1;
      drive(1'b1, 4'hB, 3'd2, 3'd2, 3'd5, 1'b1, 1'b0, 16'h0);
      tick(1'b1, "fl2_issue");
      bus.flush = 1'b1;
      drive(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0);
      tick(1'b0, "fl2_hand");
      chk("fl2_ex_valid", 64'(bus.ex_valid), 64'(0));
      chk("fl2_busy", 64'(dut.r_busy), 64'(8'h20));

      // WAW stall, released by writeback; re-set wins over the clear
      bus.flush = 1'b0;
      drive(1'b1, 4'hC, 3'd1, 3'd2, 3'd5, 1'b1, 1'b0, 16'h0);
      tick(1'b0, "waw");
      set_wb(1'b1, 3'd5, 16'h7777);
      tick(1'b1, "waw_wb");
      chk("waw_busy", 64'(dut.r_busy), 64'(8'h20));

      // Asynchronous reset mid-operation discards everything
      set_wb(1'b0, 3'd0, 16'h0);
      bus.ex_ready = 1'b0;
      drive(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ex_valid", 64'(bus.ex_valid), 64'(0));
      chk("mid_rst_busy", 64'(dut.r_busy), 64'(0));
      chk("mid_rst_ex_a", 64'(bus.ex_a), 64'(0));
      discard = sb.pop_back();
      chk("sb_drained", 64'(sb.size()), 64'(0));
      rst_n = 1'b1;
      #20;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Guard against a stuck simulation
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
